// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT0     = 2'b01;
  localparam logic [1:0] GRANT1     = 2'b10;

  localparam int DIGITS = 4;

endpackage

// File: rtl/disp_scheduler_if.sv
// Bundle between the two value sources and the display scheduler.
// Requests are levels with no ready: a source holds reqN high for as long as
// it wants the display; grant is registered and changes only at frame ends.
interface disp_scheduler_if;
  import disp_pkg::*;

  logic        req0;
  logic        req1;
  logic [15:0] src0_value;
  logic [15:0] src1_value;
  logic [1:0]  grant;
  logic [15:0] disp_value;
  logic [1:0]  digit_sel;
  logic        digit_tick;
  logic        blank;
  state_t      state_dbg;

  modport master (
    output req0, req1, src0_value, src1_value,
    input  grant, disp_value, digit_sel, digit_tick, blank, state_dbg
  );

  modport slave (
    input  req0, req1, src0_value, src1_value,
    output grant, disp_value, digit_sel, digit_tick, blank, state_dbg
  );

endinterface

// File: rtl/refresh_prescaler.sv
// Digit refresh prescaler: one digit_tick every REFRESH_DIV clocks, a 2-bit
// scan index, and frame_end on the tick that finishes the last digit.
module refresh_prescaler
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  output logic       digit_tick,
  output logic [1:0] digit_sel,
  output logic       frame_end
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       SEL_LAST = 2'(DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  // Pause gates the tick itself, so a frozen count can never emit a pulse.
  always_comb begin
    digit_tick = !pause && (cnt_q == CNT_MAX);
    frame_end  = digit_tick && (sel_q == SEL_LAST);
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    if (!pause) begin
      cnt_d = digit_tick ? '0 : cnt_q + CNT_W'(1);
    end
    if (digit_tick) begin
      sel_d = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign digit_sel = sel_q;

endmodule

// File: rtl/disp_scheduler.sv
// Time-shares the 4-digit display between two sources with per-frame,
// round-robin arbitration and a value latch updated only at frame ends.
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_FRAMES = 250,
  parameter int CNT_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  disp_scheduler_if.slave   bus
);

  localparam int                HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic              frame_end;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              last_q, last_d;   // 1 = source 1 was granted most recently
  logic [1:0]        grant_q, grant_d;
  logic              blank_q, blank_d;
  logic [15:0]       disp_q, disp_d;
  logic              own_req, other_req;
  state_t            other_state;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .digit_tick (bus.digit_tick),
    .digit_sel  (bus.digit_sel),
    .frame_end  (frame_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
      grant_q <= GRANT_NONE;
      blank_q <= 1'b1;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      blank_q <= blank_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    last_d      = last_q;
    own_req     = (state_q == SHOW1) ? bus.req1 : bus.req0;
    other_req   = (state_q == SHOW1) ? bus.req0 : bus.req1;
    other_state = (state_q == SHOW1) ? SHOW0 : SHOW1;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && bus.req1) state_d = last_q ? SHOW0 : SHOW1;
          else if (bus.req0)        state_d = SHOW0;
          else if (bus.req1)        state_d = SHOW1;
        end
        SHOW0, SHOW1: begin
          // Dropping the own request releases the display without the hold.
          if (!own_req) begin
            state_d = other_req ? other_state : IDLE;
          end else if (hold_q < HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
          end else begin
            hold_d = '0;
            if (other_req) state_d = other_state;
          end
        end
        default: state_d = IDLE;
      endcase
      if ((state_d != state_q) && (state_d != IDLE)) begin
        hold_d = '0;
        last_d = (state_d == SHOW1);
      end
    end
  end

  // Outputs follow the next state so they settle in the cycle after frame_end.
  always_comb begin
    grant_d = grant_q;
    blank_d = blank_q;
    disp_d  = disp_q;
    if (frame_end) begin
      case (state_d)
        SHOW0: begin
          grant_d = GRANT0;
          blank_d = 1'b0;
          disp_d  = bus.src0_value;
        end
        SHOW1: begin
          grant_d = GRANT1;
          blank_d = 1'b0;
          disp_d  = bus.src1_value;
        end
        default: begin
          grant_d = GRANT_NONE;
          blank_d = 1'b1;
          disp_d  = '0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.blank      = blank_q;
  assign bus.disp_value = disp_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with REFRESH_DIV=4, HOLD_FRAMES=2.
module tb_disp_scheduler;

  logic clk;
  logic reset;
  logic pause;
  int   total;
  int   passed;
  int   failed;

  disp_scheduler_if bus ();

  disp_scheduler #(
    .REFRESH_DIV (4),
    .HOLD_FRAMES (2),
    .CNT_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pause (pause),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    reset = 1'b0; pause = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.src0_value = 16'h0000; bus.src1_value = 16'h0000;

    // reset values and idle scan
    #12;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_blank", 32'(bus.blank), 32'h1);
    check("rst_disp", 32'(bus.disp_value), 32'h0);
    check("rst_sel", 32'(bus.digit_sel), 32'h0);
    check("rst_tick", 32'(bus.digit_tick), 32'h0);
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      check("idle_tick", 32'(bus.digit_tick), (c % 4 == 3) ? 32'h1 : 32'h0);
      check("idle_sel", 32'((c / 4) % 4), 32'(bus.digit_sel));
      step(1);
    end
    check("idle_grant", 32'(bus.grant), 32'h0);
    check("idle_blank", 32'(bus.blank), 32'h1);

    // single requester, mid-frame source change
    bus.req0 = 1'b1; bus.src0_value = 16'h1234;
    apply_reset();
    step(15);
    check("s0_pre_grant", 32'(bus.grant), 32'h0);
    check("s0_frame_tick", 32'(bus.digit_tick), 32'h1);
    check("s0_frame_sel", 32'(bus.digit_sel), 32'h3);
    step(1);
    check("s0_grant", 32'(bus.grant), 32'h1);
    check("s0_blank", 32'(bus.blank), 32'h0);
    check("s0_disp", 32'(bus.disp_value), 32'h1234);
    check("s0_state", 32'(bus.state_dbg), 32'h1);
    step(4);
    bus.src0_value = 16'hABCD;
    step(1);
    check("s0_disp_stable", 32'(bus.disp_value), 32'h1234);
    step(11);
    check("s0_disp_refresh", 32'(bus.disp_value), 32'hABCD);
    bus.req0 = 1'b0;
    step(16);
    check("s0_idle_grant", 32'(bus.grant), 32'h0);
    check("s0_idle_blank", 32'(bus.blank), 32'h1);
    check("s0_idle_disp", 32'(bus.disp_value), 32'h0);

    // both requesting: alternate every HOLD_FRAMES frames, src0 first
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.src0_value = 16'h00AA; bus.src1_value = 16'h00BB;
    apply_reset();
    step(16);
    for (int f = 1; f <= 5; f++) begin
      check("rr_grant", 32'(bus.grant), (((f - 1) / 2) % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_disp", 32'(bus.disp_value), (((f - 1) / 2) % 2 == 0) ? 32'h00AA : 32'h00BB);
      step(16);
    end

    // dropping own request bypasses the hold time
    bus.req0 = 1'b1; bus.req1 = 1'b0;
    apply_reset();
    step(16);
    check("byp_grant0", 32'(bus.grant), 32'h1);
    bus.req0 = 1'b0; bus.req1 = 1'b1;
    step(15);
    check("byp_stable", 32'(bus.grant), 32'h1);
    step(1);
    check("byp_grant1", 32'(bus.grant), 32'h2);
    check("byp_disp", 32'(bus.disp_value), 32'h00BB);

    // pause on a would-be tick, held for 10 cycles
    step(3);
    pause = 1'b1;
    #1;
    check("pause_tick", 32'(bus.digit_tick), 32'h0);
    bus.src1_value = 16'h0CCC;
    step(10);
    check("pause_tick_hold", 32'(bus.digit_tick), 32'h0);
    check("pause_sel", 32'(bus.digit_sel), 32'h0);
    check("pause_grant", 32'(bus.grant), 32'h2);
    check("pause_disp", 32'(bus.disp_value), 32'h00BB);
    pause = 1'b0;
    #1;
    check("resume_tick", 32'(bus.digit_tick), 32'h1);
    step(1);
    check("resume_tick_off", 32'(bus.digit_tick), 32'h0);
    check("resume_sel", 32'(bus.digit_sel), 32'h1);
    check("resume_disp", 32'(bus.disp_value), 32'h00BB);

    // asynchronous reset while in SHOW1
    #2;
    reset = 1'b0;
    #1;
    check("areset_grant", 32'(bus.grant), 32'h0);
    check("areset_blank", 32'(bus.blank), 32'h1);
    check("areset_disp", 32'(bus.disp_value), 32'h0);
    check("areset_sel", 32'(bus.digit_sel), 32'h0);
    check("areset_state", 32'(bus.state_dbg), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(2);
    check("post_rst_no_tick", 32'(bus.digit_tick), 32'h0);
    step(1);
    check("post_rst_tick", 32'(bus.digit_tick), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
Name: disp_scheduler

Overview:
- Time-shares the 4-digit seven-segment display between two 16-bit value sources, e.g. the live LFSR value (src0) and a captured or held result (src1).
- Generates the digit refresh tick and the 2-bit digit scan index.
- Arbitrates between the sources with per-frame granularity and round-robin fairness.
- Latches the displayed value only at frame boundaries, so a digit never shows a torn value.
- Sits between the LFSR/result logic and the display mux/decoder.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit tick (1 ms per digit at 100 MHz). Must be >= 2.
- HOLD_FRAMES, 250: minimum whole frames a granted source keeps the display. Must be >= 1. One frame = 4 digit ticks.
- CNT_W, 17: prescaler counter width. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pause  in  1  1 = freeze refresh scan, arbitration and displayed value.
- req0  in  1  level request from source 0.
- req1  in  1  level request from source 1.
- src0_value  in  16  source 0 value.
- src1_value  in  16  source 1 value.
- grant  out  2  one-hot grant; 00 = none.
- disp_value  out  16  value to display (registered).
- digit_sel  out  2  digit currently scanned (0 = least-significant nibble).
- digit_tick  out  1  single-cycle pulse on each digit advance.
- blank  out  1  1 = display off (no source granted).

Behaviour:
- Reset (reset=0, async), all registered:
  - prescaler=0, digit_sel=0, digit_tick=0
  - state=IDLE, grant=00, blank=1, disp_value=0
  - hold_cnt=0, last_grant=1, so src0 wins the first tie.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while pause=0.
  - digit_tick=1 for exactly the cycle in which the count is REFRESH_DIV-1, then the count wraps to 0.
  - pause=1: count holds; digit_tick=0.
- Scan:
  - digit_sel increments on digit_tick and wraps 3 -> 0.
  - frame_end = digit_tick && digit_sel==3.
- All state, grant, hold_cnt and disp_value changes happen only on frame_end. Between frame ends, outputs are stable regardless of req or src changes.
- State machine (states IDLE, SHOW0, SHOW1), evaluated at frame_end:
  - IDLE, neither req: stay in IDLE.
  - IDLE, one req: go to SHOWk.
  - IDLE, both req: go to the source != last_grant.
  - SHOWk, own req=0: go to SHOWother if the other source requests, else IDLE. This bypasses the hold time.
  - SHOWk, own req=1, hold_cnt < HOLD_FRAMES-1: stay; hold_cnt++.
  - SHOWk, own req=1, hold_cnt == HOLD_FRAMES-1, other req=1: switch to SHOWother; hold_cnt=0.
  - SHOWk, own req=1, hold_cnt == HOLD_FRAMES-1, other req=0: stay; hold_cnt=0.
  - On every entry into SHOWk, last_grant=k and hold_cnt=0.
- Outputs per state:
  - grant = 01 in SHOW0, 10 in SHOW1, 00 in IDLE. Registered; changes in the cycle after frame_end.
  - disp_value loads the granted source's value at every frame_end that leaves the scheduler in SHOWk, including stay transitions, so a live value refreshes once per frame.
  - Entering IDLE: disp_value is cleared to 0 and blank=1. In SHOWk, blank=0.
- Latency: a req asserted at cycle t is granted at most 1 frame + 1 cycle later from IDLE. When it is contending, add up to HOLD_FRAMES frames.
- Pause: a pause asserted on the same cycle as a would-be digit_tick suppresses that tick, and with it frame_end. Releasing pause resumes from the held count; no tick is lost or duplicated.
- Reset mid-frame: all state returns to reset values immediately. First digit_tick comes REFRESH_DIV cycles after release.

Decomposition:
- Shared package disp_pkg:
  - state encoding: IDLE=2'd0, SHOW0=2'd1, SHOW1=2'd2
  - GRANT_NONE / GRANT0 / GRANT1 one-hot constants
  - DIGITS=4
- Sub-module refresh_prescaler (params REFRESH_DIV, CNT_W):
  - in: clk, reset, pause
  - out: digit_tick, digit_sel, frame_end
- Arbiter FSM and value latch stay in disp_scheduler.

Test Plan (REFRESH_DIV=4, HOLD_FRAMES=2; 1 frame = 16 cycles):
- Reset then idle: grant=00, blank=1, disp_value=0. digit_tick pulses every 4 cycles and digit_sel cycles 0,1,2,3,0.
- req0=1 with src0_value=16'h1234 from cycle 0: the first frame_end falls on cycle 15, so from cycle 16 grant=01, blank=0, disp_value=16'h1234. Changing src0 to 16'hABCD mid-frame updates disp_value only after the next frame_end.
- req0=req1=1 from reset: SHOW0 for 2 frames, then SHOW1 for 2 frames, then back to SHOW0 (alternating). disp_value tracks src0=16'h00AA and src1=16'h00BB accordingly.
- In SHOW0 with hold_cnt=0, drop req0 while req1=1: switch to SHOW1 at the next frame_end without waiting for the hold time.
- pause=1 for 10 cycles mid-frame: digit_tick=0, and digit_sel, grant and disp_value hold. After release, the next tick comes after the remaining prescaler count.
- reset=0 asserted asynchronously while in SHOW1: grant=00, blank=1, disp_value=0 and digit_sel=0 immediately, without waiting for a clock edge.
